instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: branch condition codes, flag bit positions
// and the condition evaluator used by the fetch unit.
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_true(
        input logic [3:0] cc,
        input logic [3:0] f
    );
        logic n, z, c, v, r;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        r = 1'b0;
        unique case (cond_e'(cc))
            EQ: r = z;
            NE: r = ~z;
            CS: r = c;
            CC: r = ~c;
            MI: r = n;
            PL: r = ~n;
            VS: r = v;
            VC: r = ~v;
            HI: r = c & ~z;
            LS: r = ~c | z;
            GE: r = (n == v);
            LT: r = (n != v);
            GT: r = ~z & (n == v);
            LE: r = z | (n != v);
            AL: r = 1'b1;
            NV: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} entries; flush clears it
// synchronously and wins over any push/pop in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rptr_d  = rptr_q + AW'(do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues in-order memory requests, queues responses
// and redirects on taken branches, dropping responses still in flight.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 30,
    parameter int DEPTH    = 4,
    parameter int OFFSET_W = 16
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                clk_en,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_a,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                instr_valid,
    output logic [31:0]         instr_data,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    input  logic                br_valid,
    input  logic [3:0]          br_cond,
    input  logic                br_imm_mode,
    input  logic [ADDR_W-1:0]   br_pc,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic [ADDR_W-1:0]   br_target,
    input  logic [3:0]          flags,
    input  logic                halt,
    output logic                br_taken,
    output logic                halted
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic [CW-1:0]     q_count;
    logic [CW:0]       inflight;
    logic [EW-1:0]     q_rdata;
    logic [ADDR_W-1:0] tgt;
    logic              q_full, q_empty;
    logic              take, grant, keep, deq;

    always_comb begin
        tgt = br_imm_mode ? br_pc + ADDR_W'($signed(br_offset)) : br_target;
        take = nreset & clk_en & br_valid & cond_true(br_cond, flags);
        inflight = {1'b0, q_count} + {1'b0, outst_q};
        imem_req = nreset & clk_en & ~halt & ~take & ~q_full
                 & (inflight < (CW+1)'(DEPTH));
        grant = imem_req & imem_gnt;
        // Responses are accepted regardless of clk_en; stale ones are dropped.
        keep = imem_rvalid & (disc_q == '0) & ~take;
        instr_valid = clk_en & ~q_empty;
        deq = instr_valid & instr_ready;
        br_taken = take;
        halted = nreset & halt & q_empty & (outst_q == '0);

        pc_d = pc_q;
        if (take) pc_d = tgt;
        else if (grant) pc_d = pc_q + 1'b1;

        rsp_pc_d = rsp_pc_q;
        if (take) rsp_pc_d = tgt;
        else if (keep) rsp_pc_d = rsp_pc_q + 1'b1;

        outst_d = outst_q + CW'(grant) - CW'(imem_rvalid);
        disc_d  = disc_q - CW'(imem_rvalid & (disc_q != '0));
        if (take) disc_d = outst_d;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc_q     <= '0;
            rsp_pc_q <= '0;
            outst_q  <= '0;
            disc_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_queue (
        .clk   (clk),
        .nreset(nreset),
        .flush (take),
        .push  (keep),
        .wdata ({rsp_pc_q, imem_rdata}),
        .pop   (deq),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign imem_a     = pc_q;
    assign instr_data = q_rdata[31:0];
    assign instr_pc   = q_rdata[EW-1:32];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: queue-based reference model of the fetch unit
// plus a latency-randomised in-order memory, directed and random stimulus.
module tb_instr_fetch_unit;
    localparam int AW = 30;
    localparam int DEPTH = 4;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic nreset, clk_en, imem_req, imem_gnt, imem_rvalid;
    logic instr_valid, instr_ready, br_valid, br_imm_mode;
    logic halt, br_taken, halted;
    logic [AW-1:0] imem_a, instr_pc, br_pc, br_target;
    logic [31:0] imem_rdata, instr_data;
    logic [3:0] br_cond, flags;
    logic [OW-1:0] br_offset;

    instr_fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .OFFSET_W(OW)) dut (
        .clk(clk), .nreset(nreset), .clk_en(clk_en),
        .imem_req(imem_req), .imem_a(imem_a), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_pc(instr_pc), .instr_ready(instr_ready),
        .br_valid(br_valid), .br_cond(br_cond),
        .br_imm_mode(br_imm_mode), .br_pc(br_pc),
        .br_offset(br_offset), .br_target(br_target),
        .flags(flags), .halt(halt), .br_taken(br_taken),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [AW-1:0] pc; } qent_t;
    typedef struct { logic [AW-1:0] a; bit stale; int due; } fl_t;
    typedef struct { logic [3:0] cc; logic [3:0] f; bit exp; } cv_t;

    qent_t mq[$];
    fl_t fl[$];
    logic [AW-1:0] mpc;
    int cyc, lat_lo, lat_hi;
    int n_cmp = 0;
    int n_err = 0;

    logic s_req, s_valid, s_taken, s_halted;
    logic [AW-1:0] s_a, s_pc;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, ge;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        ge = (n == v);
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !(c && !z);
            4'hA: return ge;
            4'hB: return !ge;
            4'hC: return !z && ge;
            4'hD: return !(!z && ge);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [AW-1:0] model_tgt();
        longint off, t;
        if (!br_imm_mode) return br_target;
        off = longint'(br_offset);
        if (br_offset[OW-1]) off = off - (longint'(1) << OW);
        t = longint'(br_pc) + off;
        return t[AW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive memory response, check at negedge, advance model.
    task automatic step();
        bit tk, rq, vl, hl, rv;
        logic [AW-1:0] tg;
        fl_t f;
        if (!nreset) begin
            mq.delete();
            fl.delete();
            mpc = '0;
        end
        rv = nreset && fl.size() > 0 && fl[0].due <= cyc;
        imem_rvalid = rv;
        imem_rdata = rv ? mem_word(fl[0].a) : $urandom();
        @(negedge clk);
        tk = nreset && clk_en && br_valid && cond_ok(br_cond, flags);
        rq = nreset && clk_en && !halt && !tk
           && (mq.size() + fl.size() < DEPTH);
        vl = clk_en && mq.size() > 0;
        hl = nreset && halt && mq.size() == 0 && fl.size() == 0;
        tg = model_tgt();
        s_req = imem_req; s_a = imem_a; s_valid = instr_valid;
        s_pc = instr_pc; s_taken = br_taken; s_halted = halted;
        chk("req", imem_req, rq);
        chk("addr", imem_a, mpc);
        chk("valid", instr_valid, vl);
        if (vl) begin
            chk("data", instr_data, mq[0].d);
            chk("pc", instr_pc, mq[0].pc);
        end
        chk("taken", br_taken, tk);
        chk("halted", halted, hl);
        @(posedge clk);
        if (nreset) begin
            if (vl && instr_ready) void'(mq.pop_front());
            if (rv) begin
                f = fl.pop_front();
                if (!f.stale && !tk) mq.push_back('{d: mem_word(f.a), pc: f.a});
            end
            if (tk) begin
                mq.delete();
                foreach (fl[i]) fl[i].stale = 1'b1;
                mpc = tg;
            end else if (rq && imem_gnt) begin
                fl.push_back('{a: mpc, stale: 1'b0,
                    due: cyc + int'($urandom_range(lat_hi, lat_lo))});
                mpc = mpc + 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        br_valid = 1'b0; halt = 1'b0; clk_en = 1'b1;
        imem_gnt = 1'b0; instr_ready = 1'b0;
        step();
        nreset = 1'b1;
    endtask

    cv_t tbl[12];
    logic [AW-1:0] pcs[4];
    int cs[4];
    int k, bad;
    logic [AW-1:0] prev, first, ones;

    initial begin
        nreset = 1'b0; clk_en = 1'b1; halt = 1'b0; imem_gnt = 1'b0;
        instr_ready = 1'b0; br_valid = 1'b0; br_cond = 4'hF;
        br_imm_mode = 1'b0; br_pc = '0; br_offset = '0; br_target = '0;
        flags = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        lat_lo = 1; lat_hi = 1; cyc = 0; mpc = '0; ones = '1;
        tbl = '{
            '{4'hB, 4'b1000, 1'b1}, '{4'hA, 4'b1000, 1'b0},
            '{4'hF, 4'b1111, 1'b0}, '{4'hF, 4'b0000, 1'b0},
            '{4'hE, 4'b0000, 1'b1}, '{4'h0, 4'b0100, 1'b1},
            '{4'h0, 4'b0000, 1'b0}, '{4'h8, 4'b0010, 1'b1},
            '{4'h8, 4'b0110, 1'b0}, '{4'hC, 4'b0000, 1'b1},
            '{4'hD, 4'b1000, 1'b1}, '{4'h9, 4'b0000, 1'b1}
        };
        #1;

        halt = 1'b1; br_valid = 1'b1; br_cond = 4'hE;
        step();
        chk("rst_req", s_req, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_taken", s_taken, 0);
        chk("rst_halted", s_halted, 0);
        nreset = 1'b1; halt = 1'b0; br_valid = 1'b0;

        imem_gnt = 1'b1; instr_ready = 1'b1; k = 0;
        foreach (pcs[i]) begin pcs[i] = '1; cs[i] = 0; end
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_valid && k < 4) begin pcs[k] = s_pc; cs[k] = cyc; k++; end
        end
        chk("stream_n", k, 4);
        for (int i = 0; i < 4; i++) begin
            chk("stream_pc", pcs[i], i);
            if (i > 0) chk("stream_gap", cs[i] - cs[i-1], 1);
        end

        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("bp_req", s_req, 0);
        chk("bp_valid", s_valid, 1);
        instr_ready = 1'b1; k = 0; prev = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid) begin
                if (k > 0) chk("bp_seq", s_pc, prev + 1'b1);
                prev = s_pc; k++;
            end
        end
        chk("bp_n", k, 10);

        do_reset();
        lat_lo = 5; lat_hi = 5; instr_ready = 1'b1; imem_gnt = 1'b1;
        step(); step();
        imem_gnt = 1'b0;
        br_valid = 1'b1; br_imm_mode = 1'b1; br_pc = 10;
        br_offset = 16'hFFFC; br_cond = 4'hE;
        step();
        chk("br_taken", s_taken, 1);
        chk("br_req_low", s_req, 0);
        br_valid = 1'b0; imem_gnt = 1'b1; lat_lo = 1; lat_hi = 1;
        step();
        chk("br_next_a", s_a, 6);
        imem_gnt = 1'b0; k = 0; bad = 0; first = '1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_valid) begin
                if (k == 0) first = s_pc;
                if (s_pc < 6) bad++;
                k++;
            end
        end
        chk("br_first", first, 6);
        chk("br_stale", bad, 0);

        imem_gnt = 1'b0; br_imm_mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            br_valid = 1'b1; br_cond = tbl[i].cc; flags = tbl[i].f;
            br_target = AW'($urandom());
            step();
            chk($sformatf("cond_%0d", i), s_taken, tbl[i].exp);
            br_valid = 1'b0;
            step();
        end
        br_valid = 1'b1; br_cond = 4'hE; br_target = ones;
        step();
        br_valid = 1'b0; imem_gnt = 1'b1;
        step();
        chk("wrap_hi", s_a, ones);
        step();
        chk("wrap_lo", s_a, 0);

        do_reset();
        lat_lo = 1; lat_hi = 1; imem_gnt = 1'b1;
        step(); step(); step();
        imem_gnt = 1'b0;
        step(); step();
        halt = 1'b1; imem_gnt = 1'b1;
        step();
        chk("h_req", s_req, 0);
        chk("h_halted0", s_halted, 0);
        instr_ready = 1'b1;
        step(); step(); step();
        instr_ready = 1'b0;
        step();
        chk("h_halted1", s_halted, 1);
        halt = 1'b0;
        step();
        chk("h_req_resume", s_req, 1);
        chk("h_addr", s_a, 3);

        lat_lo = 2; lat_hi = 2; instr_ready = 1'b1; imem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) step();
        nreset = 1'b0;
        #1;
        chk("mr_req_imm", imem_req, 0);
        chk("mr_valid_imm", instr_valid, 0);
        step();
        chk("mr_a", s_a, 0);
        nreset = 1'b1;
        step();
        chk("mr_next_a", s_a, 0);
        chk("mr_next_req", s_req, 1);

        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            clk_en = ($urandom() % 10) != 0;
            imem_gnt = ($urandom() % 4) != 0;
            instr_ready = ($urandom() % 10) < 7;
            if (($urandom() % 20) == 0) halt = ~halt;
            br_valid = ($urandom() % 8) == 0;
            br_cond = 4'($urandom());
            flags = 4'($urandom());
            br_imm_mode = 1'($urandom());
            br_pc = AW'($urandom());
            br_offset = OW'($urandom());
            br_target = AW'($urandom());
            nreset = ($urandom() % 400) != 0;
            step();
        end
        nreset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
